// File: rtl/ex_div_if.sv
// Handshake/operand bundle between the EX stage and the iterative divider.
// The EX stage drives the master side; the divider implements the slave side.
interface ex_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  flush;
    logic [1:0]            div_op;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
    logic                  stall_req;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, flush, div_op, rs1, rs2,
        input  stall_req, busy, done, result
    );

    modport slave (
        input  start, flush, div_op, rs1, rs2,
        output stall_req, busy, done, result
    );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Latency: DATA_WIDTH+2 cycles from start to done; divide-by-zero and signed overflow finish in 1.
// Backpressure: stall_req freezes the front of the pipeline until the done cycle; start is ignored while busy.
module ex_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    ex_div_if.slave   bus
);
    localparam int          W    = DATA_WIDTH;
    localparam logic [5:0]  LAST = 6'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state;
    logic [5:0]     counter;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   dvsr;
    logic [W-1:0]   result_q;
    logic [1:0]     op_q;
    logic           sign_a;
    logic           sign_b;
    logic           busy_q;
    logic           done_q;

    logic           is_signed;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           div_zero;
    logic           ovf;
    logic [W-1:0]   fast_res;
    logic [W:0]     rem_sh;
    logic [W:0]     diff;
    logic [W-1:0]   q_fix;
    logic [W-1:0]   r_fix;
    logic [W-1:0]   fix_res;

    // Operand decode is only meaningful in IDLE, where the op is accepted.
    always_comb begin
        is_signed = ~bus.div_op[0];
        a_neg     = is_signed & bus.rs1[W-1];
        b_neg     = is_signed & bus.rs2[W-1];
        a_mag     = a_neg ? (~bus.rs1 + 1'b1) : bus.rs1;
        b_mag     = b_neg ? (~bus.rs2 + 1'b1) : bus.rs2;
        div_zero  = (bus.rs2 == '0);
        ovf       = is_signed && (bus.rs1 == {1'b1, {(W-1){1'b0}}}) && (bus.rs2 == '1);
        if (div_zero)
            fast_res = bus.div_op[1] ? bus.rs1 : '1;
        else
            fast_res = bus.div_op[1] ? '0 : bus.rs1;
    end

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        rem_sh  = {rem, quo[W-1]};
        diff    = rem_sh - {1'b0, dvsr};
        q_fix   = (sign_a ^ sign_b) ? (~quo + 1'b1) : quo;
        r_fix   = sign_a ? (~rem + 1'b1) : rem;
        fix_res = op_q[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            counter  <= '0;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            result_q <= '0;
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.flush) begin
            state   <= IDLE;
            counter <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q    <= bus.div_op;
                        sign_a  <= a_neg;
                        sign_b  <= b_neg;
                        quo     <= a_mag;
                        rem     <= '0;
                        dvsr    <= b_mag;
                        counter <= '0;
                        busy_q  <= 1'b1;
                        if (div_zero || ovf) begin
                            result_q <= fast_res;
                            state    <= DONE;
                            done_q   <= 1'b1;
                        end else begin
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!diff[W]) begin
                        rem <= diff[W-1:0];
                        quo <= {quo[W-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[W-1:0];
                        quo <= {quo[W-2:0], 1'b0};
                    end
                    if (counter == LAST) begin
                        counter <= '0;
                        state   <= FIX;
                    end else begin
                        counter <= counter + 6'd1;
                    end
                end
                FIX: begin
                    result_q <= fix_res;
                    state    <= DONE;
                    done_q   <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Combinational on start so the front end holds in the accept cycle itself.
    assign bus.stall_req = ((state == IDLE) && bus.start && !bus.flush) ||
                           (state == CALC) || (state == FIX);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// Scoreboard bench for ex_div_unit: directed corner cases, flush/reset aborts, then random ops.
module tb_ex_div_unit;
    localparam int W = 32;
    localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] sb[$];

    ex_div_if #(.DATA_WIDTH(W)) dif ();

    ex_div_unit #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb_;
        sa  = a;
        sb_ = b;
        if (b == 0)
            return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   return (a == MIN_INT && b == 32'hFFFF_FFFF) ? a : W'(sa / sb_);
            2'b01:   return a / b;
            2'b10:   return (a == MIN_INT && b == 32'hFFFF_FFFF) ? '0 : W'(sa % sb_);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
        return W + 2;
    endfunction

    always @(negedge clk) begin
        if (rst_n && dif.done) begin
            if (sb.size() == 0)
                check("spurious_done", 1, 0);
            else
                check("result", dif.result, sb.pop_front());
        end
    end

    // Starts an op in the current cycle (called #1 after a rising edge) and tracks done/stall timing.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold);
        int cyc, done_cyc, nst, lat;
        lat = ref_lat(op, a, b);
        dif.start  = 1'b1;
        dif.flush  = 1'b0;
        dif.div_op = op;
        dif.rs1    = a;
        dif.rs2    = b;
        sb.push_back(ref_div(op, a, b));
        cyc = 0;
        done_cyc = -1;
        nst = 0;
        while (cyc <= 3 * W && done_cyc < 0) begin
            @(negedge clk);
            if (dif.stall_req) nst++;
            if (dif.done) begin
                done_cyc = cyc;
                check("stall_in_done", W'(dif.stall_req), 0);
            end
            @(posedge clk);
            #1;
            if (!hold || done_cyc >= 0) dif.start = 1'b0;
            dif.rs1    = $urandom;
            dif.rs2    = $urandom;
            dif.div_op = 2'($urandom);
            cyc++;
        end
        check("done_cycle", W'(done_cyc), W'(lat));
        check("stall_cycles", W'(nst), W'(lat));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        logic [1:0] op;
        logic [W-1:0] a, b;
        dif.start  = 1'b0;
        dif.flush  = 1'b0;
        dif.div_op = '0;
        dif.rs1    = '0;
        dif.rs2    = '0;
        tick(3);
        @(negedge clk);
        check("rst_busy", W'(dif.busy), 0);
        check("rst_done", W'(dif.done), 0);
        check("rst_stall", W'(dif.stall_req), 0);
        check("rst_result", dif.result, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);

        run_op(2'b01, 32'd100, 32'd7, 1'b0);
        run_op(2'b10, -32'sd7, 32'd2, 1'b0);
        run_op(2'b00, -32'sd7, 32'd2, 1'b0);
        run_op(2'b00, MIN_INT, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, MIN_INT, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'd5, 32'd0, 1'b0);
        run_op(2'b10, -32'sd5, 32'd0, 1'b0);
        run_op(2'b01, 32'd5, 32'd0, 1'b0);
        run_op(2'b11, 32'd5, 32'd0, 1'b0);
        tick(2);

        // Flush in cycle 10 of DIV 1000/3: no done, result keeps 5.
        dif.start = 1'b1; dif.div_op = 2'b00; dif.rs1 = 32'd1000; dif.rs2 = 32'd3;
        tick(1);
        dif.start = 1'b0;
        tick(9);
        dif.flush = 1'b1;
        tick(1);
        dif.flush = 1'b0;
        @(negedge clk);
        check("flush_busy", W'(dif.busy), 0);
        check("flush_stall", W'(dif.stall_req), 0);
        check("flush_result", dif.result, 32'd5);
        ndone = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            if (dif.done) ndone++;
        end
        check("flush_no_done", W'(ndone), 0);
        @(posedge clk);
        #1;

        // Reset in cycle 20 of an op.
        dif.start = 1'b1; dif.div_op = 2'b00; dif.rs1 = 32'd1000; dif.rs2 = 32'd3;
        tick(1);
        dif.start = 1'b0;
        tick(19);
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        check("mid_rst_busy", W'(dif.busy), 0);
        check("mid_rst_done", W'(dif.done), 0);
        check("mid_rst_stall", W'(dif.stall_req), 0);
        check("mid_rst_result", dif.result, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(2'b01, 32'd9, 32'd3, 1'b0);

        // Back-to-back: second start lands in the IDLE cycle after DONE.
        run_op(2'b11, 32'd17, 32'd5, 1'b0);
        run_op(2'b01, 32'd17, 32'd5, 1'b0);

        // start held through DONE must not launch a second op.
        run_op(2'b00, 32'd1000, 32'd3, 1'b1);
        tick(4);
        check("hold_idle", W'(dif.busy), 0);

        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: begin a = MIN_INT; b = 32'hFFFF_FFFF; end
                3: b = -32'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            run_op(op, a, b, 1'b0);
        end

        tick(3);
        check("sb_empty", W'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
